key_event_scheduler: RTL and testbench
======================================

# key_event_scheduler

Sits between the `keys` debounce/auto-repeat block and the game logic. It captures the one-cycle per-key pulses that block emits, arbitrates simultaneous keys round-robin, and queues them as a stream of key-ID events in a small FIFO. The game logic consumes the stream through a valid/ready handshake, so no press is lost while it is busy. Events that cannot be held are flagged with a sticky overflow bit.

## Interface
- `NUM_KEYS`, default 4: number of key pulse inputs; must be ≥2.
- `FIFO_DEPTH`, default 4: event queue depth; must be a power of two and ≥2.
- `CLOCK_50`  in  1: system clock, 50 MHz.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `key_pulse`  in  `NUM_KEYS`: one-cycle event pulses, one per key, from `keys`.
- `ev_valid`  out  1: event available at queue head.
- `ev_key`  out  `$clog2(NUM_KEYS)`: key index of head event.
- `ev_ready`  in  1: consumer accepts head event.
- `pending`  out  `NUM_KEYS`: keys captured but not yet queued.
- `fifo_count`  out  `$clog2(FIFO_DEPTH)+1`: queued events, 0..`FIFO_DEPTH`.
- `overflow`  out  1: sticky; at least one event was lost.
- `overflow_clr`  in  1: clears `overflow`.

## Operation
- Reset values: `pending`=0, FIFO empty, `fifo_count`=0, `ev_valid`=0, `ev_key`=0, `overflow`=0, round-robin pointer `rr_ptr`=0.
- Capture: `key_pulse[i]`=1 sets `pending[i]` at the next edge.
- Grant condition: the registered `fifo_count` < `FIFO_DEPTH` and `pending` != 0.
- Grant: at most one key per cycle. The search starts at `rr_ptr` and wraps modulo `NUM_KEYS`.
- On a grant to key k:
  - k is pushed into the FIFO.
  - `pending[k]` is cleared.
  - `rr_ptr` becomes (k+1) mod `NUM_KEYS`.
- Grant and new pulse on the same key in the same cycle: the pulse wins. `pending[k]` stays 1, which queues a second event later.
- Lost event: a pulse on key i while `pending[i]`=1 and key i is not granted that cycle.
  - The pulse merges into the existing pending bit, so the event is lost.
  - `overflow` is set.
- FIFO full: no grant is made and `pending` bits are held. A pop in the same cycle does not enable a grant, because the grant decision uses the registered count.
- Output handshake:
  - `ev_valid` = (`fifo_count` != 0); `ev_key` = head entry.
  - A pop happens on `ev_valid` && `ev_ready`.
  - `ev_key` must stay stable while `ev_valid` && !`ev_ready`.
- Push and pop in the same cycle: `fifo_count` is unchanged and head/tail both advance.
- Pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally. Full/empty is derived from `fifo_count`, not from pointer equality.
- `overflow` is sticky until `overflow_clr`=1. If a set and a clear occur in the same cycle, the set wins.
- `ev_ready` with `ev_valid`=0 is ignored.

## Timing
- Pulse to `ev_valid`, with an empty FIFO and the key not pending:
  - cycle N: pulse;
  - edge N+1: `pending` set;
  - edge N+2: event pushed; `ev_valid`=1 in cycle N+2.
- Throughput: one grant per cycle and one pop per cycle sustained.
- All outputs are registered except `ev_valid` and `ev_key`, which decode directly from registered FIFO state.
- Reset mid-operation: `reset_n` low clears all state immediately (asynchronously). Queued and pending events are discarded.

## Structure
- Shared package `key_ctrl_pkg`:
  - default `NUM_KEYS`, `FIFO_DEPTH`;
  - `KEY_ID_W` = `$clog2(NUM_KEYS)`;
  - typedef `key_id_t`.
- Sub-module `key_event_fifo`:
  - synchronous FIFO of `key_id_t` with push/pop/count;
  - same clock and reset ports;
  - shows first-word data at the head.
- The top level holds the capture register, the round-robin arbiter, the overflow logic and the FIFO instance.

## Test plan
1. Lone pulse, empty FIFO, `ev_ready`=1:
   - stimulus: `key_pulse`=4'b0100 for 1 cycle;
   - response: `ev_valid`=1 exactly one cycle, 2 cycles later, with `ev_key`=2; `fifo_count` returns to 0.
2. Simultaneous keys, `ev_ready`=1:
   - stimulus: `key_pulse`=4'b1111, then `key_pulse`=4'b0101 after the queue drains;
   - response: events 0,1,2,3 on consecutive cycles; then 0,2 (`rr_ptr` wrapped to 0).
3. Fill and overflow, `ev_ready`=0:
   - stimulus: pulses on keys 0,1,2,3 on separate cycles, then key 0 twice;
   - response: `fifo_count`=4 and `pending`=4'b0001 with `overflow`=0; the second key-0 pulse sets `overflow`=1;
   - drain with `ev_ready`=1: output order 0,1,2,3,0.
4. Backpressure with simultaneous push/pop:
   - with `ev_ready`=0, `ev_key` is held stable over 10 cycles;
   - `ev_ready`=1 plus a new pulse with count 2 keeps count at 2 for that cycle, and order is preserved.
5. Overflow clear priority:
   - `overflow_clr`=1 alone clears `overflow`;
   - `overflow_clr` in the same cycle as a lost pulse leaves `overflow`=1.
6. Reset mid-operation:
   - stimulus: `reset_n` low while `fifo_count`=3 and `pending`=4'b1000;
   - response: all outputs are 0 immediately. After release, no event appears until a new pulse, and the first grant starts searching from key 0.

Source files
------------

// File: rtl/key_ctrl_pkg.sv
// Shared definitions for the key event path: default sizing and the key-ID type.
package key_ctrl_pkg;
  localparam int NUM_KEYS_DEFAULT   = 4;
  localparam int FIFO_DEPTH_DEFAULT = 4;
  localparam int KEY_ID_W           = $clog2(NUM_KEYS_DEFAULT);

  typedef logic [KEY_ID_W-1:0] key_id_t;
endpackage

// File: rtl/key_event_fifo.sv
// Small synchronous FIFO of key IDs with first-word-fall-through head and occupancy count.
module key_event_fifo
  import key_ctrl_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter  int ID_W  = $bits(key_id_t),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             push,
  input  logic [ID_W-1:0]  push_id,
  input  logic             pop,
  output logic [ID_W-1:0]  head_id,
  output logic [CNT_W-1:0] count
);

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [ID_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  // Full/empty come from the count; pointers simply wrap at the power-of-two depth.
  assign pop_ok  = pop && (cnt_q != '0);
  assign push_ok = push && (cnt_q != CNT_W'(DEPTH));

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_id = mem_q[rd_ptr_q];
  assign count   = cnt_q;

endmodule

// File: rtl/key_event_scheduler.sv
// Captures per-key pulses, grants one pending key per cycle round-robin into an
// event FIFO, and flags pulses that merge into an already-pending key as lost.
module key_event_scheduler
  import key_ctrl_pkg::*;
#(
  parameter  int NUM_KEYS   = NUM_KEYS_DEFAULT,
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int KEY_W      = $clog2(NUM_KEYS),
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_pulse,
  output logic                ev_valid,
  output logic [KEY_W-1:0]    ev_key,
  input  logic                ev_ready,
  output logic [NUM_KEYS-1:0] pending,
  output logic [CNT_W-1:0]    fifo_count,
  output logic                overflow,
  input  logic                overflow_clr
);

  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [KEY_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                overflow_q, overflow_d;

  logic                grant;
  logic [KEY_W-1:0]    grant_id;
  logic [NUM_KEYS-1:0] grant_oh;
  logic                space;
  logic                lost;
  logic                pop;
  int                  idx;
  logic [KEY_W-1:0]    idx_w;

  // Grant is decided on the registered count, so a same-cycle pop never frees a slot early.
  assign space = (fifo_count < CNT_W'(FIFO_DEPTH));

  always_comb begin
    grant    = 1'b0;
    grant_id = '0;
    grant_oh = '0;
    idx      = 0;
    idx_w    = '0;
    for (int off = 0; off < NUM_KEYS; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= NUM_KEYS) idx = idx - NUM_KEYS;
      idx_w = KEY_W'(idx);
      if (space && !grant && pending_q[idx_w]) begin
        grant           = 1'b1;
        grant_id        = idx_w;
        grant_oh[idx_w] = 1'b1;
      end
    end
  end

  always_comb begin
    // A pulse on the key being granted re-arms it rather than being lost.
    pending_d  = (pending_q & ~grant_oh) | key_pulse;
    lost       = |(key_pulse & pending_q & ~grant_oh);
    overflow_d = overflow_q;
    if (lost) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (grant_id == KEY_W'(NUM_KEYS - 1)) ? '0 : grant_id + KEY_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign pop = ev_valid && ev_ready;

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .ID_W  (KEY_W)
  ) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .push     (grant),
    .push_id  (grant_id),
    .pop      (pop),
    .head_id  (ev_key),
    .count    (fifo_count)
  );

  assign ev_valid = (fifo_count != '0);
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Scenario bench for key_event_scheduler with a queue-based reference model.
module tb_key_event_scheduler;
  localparam int N      = 4;
  localparam int D      = 4;
  localparam int KW     = 2;
  localparam int CW     = 3;
  localparam int SNAP_W = 1 + KW + CW + N + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  key_pulse = '0;
  logic          ev_ready = 1'b0;
  logic          overflow_clr = 1'b0;
  logic          ev_valid;
  logic [KW-1:0] ev_key;
  logic [N-1:0]  pending;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int           mq[$];
  logic [N-1:0] m_pend;
  int           m_rr;
  logic         m_ovf;

  int got[$];
  int got_cyc[$];

  key_event_scheduler #(.NUM_KEYS(N), .FIFO_DEPTH(D)) dut (
    .CLOCK_50     (clk),
    .reset_n      (rst_n),
    .key_pulse    (key_pulse),
    .ev_valid     (ev_valid),
    .ev_key       (ev_key),
    .ev_ready     (ev_ready),
    .pending      (pending),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #10 clk = ~clk;

  logic [SNAP_W-1:0] dut_snap;
  assign dut_snap = {ev_valid, (ev_valid ? ev_key : KW'(0)), fifo_count, pending, overflow};

  function automatic void model_clear();
    mq.delete();
    m_pend = '0;
    m_rr   = 0;
    m_ovf  = 1'b0;
  endfunction

  function automatic void model_step();
    int   g;
    int   k;
    logic lost;
    logic pop;
    g    = -1;
    lost = 1'b0;
    pop  = (mq.size() != 0) && ev_ready;
    if (mq.size() < D) begin
      for (int o = 0; o < N; o++) begin
        k = (m_rr + o) % N;
        if (g < 0 && m_pend[k]) g = k;
      end
    end
    for (int i = 0; i < N; i++)
      if (key_pulse[i] && m_pend[i] && i != g) lost = 1'b1;
    if (lost) m_ovf = 1'b1;
    else if (overflow_clr) m_ovf = 1'b0;
    if (pop) void'(mq.pop_front());
    if (g >= 0) begin
      mq.push_back(g);
      m_pend[g] = 1'b0;
      m_rr = (g + 1) % N;
    end
    m_pend = m_pend | key_pulse;
  endfunction

  function automatic logic [SNAP_W-1:0] exp_snap();
    logic [KW-1:0] k;
    logic          v;
    v = (mq.size() != 0);
    k = v ? KW'(mq[0]) : KW'(0);
    return {v, k, CW'(mq.size()), m_pend, m_ovf};
  endfunction

  // Inputs are set at the falling edge; pulses and clears last one cycle.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    key_pulse    = '0;
    overflow_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    key_pulse    = '0;
    ev_ready     = 1'b0;
    overflow_clr = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if ({ev_valid, ev_key, fifo_count, pending, overflow} !== '0)
      $display("FAIL reset_state: got %b want 0", {ev_valid, ev_key, fifo_count, pending, overflow});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (dut_snap !== exp_snap()) $display("FAIL reset_idle: got %b want %b", dut_snap, exp_snap());
    else n_pass++;
  endtask

  task automatic test_lone_pulse();
    do_reset();
    ev_ready  = 1'b1;
    key_pulse = 4'b0100;
    tick();
    n_checks++;
    if (pending !== 4'b0100 || ev_valid !== 1'b0)
      $display("FAIL lone_capture: pending=%b valid=%b want 0100/0", pending, ev_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (ev_valid !== 1'b1 || ev_key !== 2'd2)
      $display("FAIL lone_event: valid=%b key=%0d want 1/2", ev_valid, ev_key);
    else n_pass++;
    tick();
    n_checks++;
    if (ev_valid !== 1'b0 || fifo_count !== 3'd0)
      $display("FAIL lone_drained: valid=%b count=%0d want 0/0", ev_valid, fifo_count);
    else n_pass++;
    n_checks++;
    if (dut_snap !== exp_snap()) $display("FAIL lone_model: got %b want %b", dut_snap, exp_snap());
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int exp1[4] = '{0, 1, 2, 3};
    int exp2[2] = '{0, 2};
    do_reset();
    ev_ready  = 1'b1;
    key_pulse = 4'b1111;
    got.delete();
    got_cyc.delete();
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ev_valid) begin
        got.push_back(int'(ev_key));
        got_cyc.push_back(c);
      end
    end
    n_checks++;
    if (got.size() != 4) $display("FAIL simul_count: got %0d events want 4", got.size());
    else begin
      n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got[i] != exp1[i] || got_cyc[i] != got_cyc[0] + i)
          $display("FAIL simul_order[%0d]: key=%0d cyc=%0d want key=%0d cyc=%0d",
                   i, got[i], got_cyc[i], exp1[i], got_cyc[0] + i);
        else n_pass++;
      end
    end
    key_pulse = 4'b0101;
    got.delete();
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ev_valid) got.push_back(int'(ev_key));
    end
    n_checks++;
    if (got.size() != 2 || got[0] != exp2[0] || got[1] != exp2[1])
      $display("FAIL simul_wrap: got %p want %p", got, exp2);
    else n_pass++;
  endtask

  task automatic test_fill_overflow();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    ev_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      key_pulse = N'(1) << k;
      tick();
    end
    key_pulse = 4'b0001;
    tick();
    n_checks++;
    if (fifo_count !== 3'd4 || pending !== 4'b0001 || overflow !== 1'b0)
      $display("FAIL fill_full: count=%0d pending=%b ovf=%b want 4/0001/0", fifo_count, pending, overflow);
    else n_pass++;
    key_pulse = 4'b0001;
    tick();
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL fill_overflow: ovf=%b want 1", overflow);
    else n_pass++;
    ev_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 10; c++) begin
      if (ev_valid) got.push_back(int'(ev_key));
      tick();
    end
    n_checks++;
    if (got.size() != 5) $display("FAIL fill_drain_len: got %0d want 5", got.size());
    else begin
      n_pass++;
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (got[i] != exp_order[i]) $display("FAIL fill_drain[%0d]: got %0d want %0d", i, got[i], exp_order[i]);
        else n_pass++;
      end
    end
    n_checks++;
    if (fifo_count !== 3'd0) $display("FAIL fill_empty: count=%0d want 0", fifo_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int exp_order[3] = '{1, 3, 0};
    int unstable;
    do_reset();
    ev_ready  = 1'b0;
    key_pulse = 4'b0010;
    tick();
    key_pulse = 4'b1000;
    tick();
    tick();
    n_checks++;
    if (fifo_count !== 3'd2) $display("FAIL bp_count: count=%0d want 2", fifo_count);
    else n_pass++;
    unstable = 0;
    for (int c = 0; c < 10; c++) begin
      if (ev_valid !== 1'b1 || ev_key !== 2'd1) unstable++;
      tick();
    end
    n_checks++;
    if (unstable != 0) $display("FAIL bp_stable: %0d unstable cycles want 0", unstable);
    else n_pass++;
    key_pulse = 4'b0001;
    tick();
    ev_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 6; c++) begin
      if (ev_valid) got.push_back(int'(ev_key));
      tick();
      if (c == 0) begin
        n_checks++;
        if (fifo_count !== 3'd2) $display("FAIL bp_push_pop: count=%0d want 2", fifo_count);
        else n_pass++;
      end
    end
    n_checks++;
    if (got.size() != 3 || got[0] != exp_order[0] || got[1] != exp_order[1] || got[2] != exp_order[2])
      $display("FAIL bp_order: got %p want %p", got, exp_order);
    else n_pass++;
  endtask

  task automatic test_overflow_clr();
    do_reset();
    ev_ready  = 1'b0;
    key_pulse = 4'b1111;
    for (int c = 0; c < 5; c++) tick();
    key_pulse = 4'b0001;
    tick();
    key_pulse = 4'b0001;
    tick();
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL clr_setup: ovf=%b want 1", overflow);
    else n_pass++;
    overflow_clr = 1'b1;
    tick();
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL clr_alone: ovf=%b want 0", overflow);
    else n_pass++;
    key_pulse    = 4'b0001;
    overflow_clr = 1'b1;
    tick();
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL clr_set_wins: ovf=%b want 1", overflow);
    else n_pass++;
    n_checks++;
    if (dut_snap !== exp_snap()) $display("FAIL clr_model: got %b want %b", dut_snap, exp_snap());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    ev_ready  = 1'b0;
    key_pulse = 4'b0111;
    tick();
    tick();
    tick();
    key_pulse = 4'b1000;
    tick();
    n_checks++;
    if (fifo_count !== 3'd3 || pending !== 4'b1000)
      $display("FAIL mid_setup: count=%0d pending=%b want 3/1000", fifo_count, pending);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ev_valid, ev_key, fifo_count, pending, overflow} !== '0)
      $display("FAIL mid_async_clear: got %b want 0", {ev_valid, ev_key, fifo_count, pending, overflow});
    else n_pass++;
    model_clear();
    @(negedge clk);
    rst_n    = 1'b1;
    ev_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ev_valid) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL mid_no_stale: %0d events want 0", seen);
    else n_pass++;
    key_pulse = 4'b1010;
    got.delete();
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ev_valid) got.push_back(int'(ev_key));
    end
    n_checks++;
    if (got.size() != 2 || got[0] != 1 || got[1] != 3)
      $display("FAIL mid_rr_restart: got %p want 1,3", got);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      key_pulse    = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      ev_ready     = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      overflow_clr = ($urandom_range(0, 15) == 0);
      tick();
      n_checks++;
      if (dut_snap !== exp_snap())
        $display("FAIL random[%0d]: got %b want %b", c, dut_snap, exp_snap());
      else n_pass++;
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_lone_pulse();
    test_simultaneous();
    test_fill_overflow();
    test_back_to_back();
    test_overflow_clr();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
